irrigacao_zonas: RTL and testbench

//  Multi-zone successor of the single-valve garden irrigation controller.
//  - Inputs: debounced active-low keys (dawn, dusk, manual/abort).
//  - Waters ZONES valves one at a time in ascending order, each for a

---
 rtl/irrigacao_zonas.sv | 151 +++++++++++++++
 tb/tb_irrigacao_zonas.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigacao_zonas.sv
// irrigacao_zonas: debounced keys start a dawn/dusk cycle that waters enabled zones one at a time, in ascending order.
// Press pulse to valve open takes 2 cycles, with no backpressure. Defining CHUVA_EN adds a rain input that pauses watering.
module irrigacao_zonas #(
  parameter int ZONES         = 4,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DAWN_SECS     = 3,
  parameter int DUSK_SECS     = 6,
  parameter int DEB_CYCLES    = 1_000_000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   amanhecer,
  input  logic                   anoitecer,
  input  logic                   controle,
  input  logic [ZONES-1:0]       zone_en,
`ifdef CHUVA_EN
  input  logic                   chuva,
`endif
  output logic [ZONES-1:0]       valve,
  output logic [$clog2(ZONES):0] zona,
  output logic                   LEDG,
  output logic                   LEDR
);

  localparam int IW     = $clog2(ZONES) + 1;
  localparam int D_DAWN = DAWN_SECS * TICKS_PER_SEC;
  localparam int D_DUSK = DUSK_SECS * TICKS_PER_SEC;
  localparam int TW     = $clog2(D_DUSK + 1);
  localparam int CW     = $clog2(DEB_CYCLES + 1);
  localparam int NK     = 3;

  typedef enum logic [1:0] {IDLE, SELECT, WATER} state_t;

  // Key order: bit 2 controle, bit 1 anoitecer, bit 0 amanhecer.
  logic [NK-1:0] key_raw;
  logic [NK-1:0] sync1, sync2, deb, press;
  logic [CW-1:0] deb_cnt [NK];

  assign key_raw = {controle, anoitecer, amanhecer};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      for (int k = 0; k < NK; k++) deb_cnt[k] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int k = 0; k < NK; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == CW'(DEB_CYCLES - 1)) begin
          deb[k]     <= sync2[k];
          deb_cnt[k] <= '0;
          press[k]   <= ~sync2[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + CW'(1);
        end
      end
    end
  end

  logic rain_s;
`ifdef CHUVA_EN
  logic rain_s1;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rain_s1 <= 1'b0;
      rain_s  <= 1'b0;
    end else begin
      rain_s1 <= chuva;
      rain_s  <= rain_s1;
    end
  end
`else
  assign rain_s = 1'b0;
`endif

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          dusk, dusk_nx;
  logic [ZONES-1:0] en_sh;

  assign en_sh = zone_en >> idx;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      timer <= '0;
      dusk  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      timer <= timer_nx;
      dusk  <= dusk_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    timer_nx = timer;
    dusk_nx  = dusk;
    unique case (state)
      IDLE: begin
        // Rain only blocks the scheduled keys; controle always starts a dusk-length cycle.
        if (press[2] || (!rain_s && (press[1] || press[0]))) begin
          state_nx = SELECT;
          idx_nx   = '0;
          dusk_nx  = press[2] | press[1];
        end
      end
      SELECT: begin
        if (press[2] || idx == IW'(ZONES)) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else if (!en_sh[0]) begin
          idx_nx = idx + IW'(1);
        end else begin
          timer_nx = dusk ? TW'(D_DUSK - 1) : TW'(D_DAWN - 1);
          state_nx = WATER;
        end
      end
      WATER: begin
        if (press[2]) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else if (!rain_s) begin
          if (timer == '0) begin
            idx_nx   = idx + IW'(1);
            state_nx = SELECT;
          end else begin
            timer_nx = timer - TW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign valve = (state == WATER && !rain_s) ? (ZONES'(1) << idx) : '0;
  assign zona  = (state == WATER) ? (idx + IW'(1)) : '0;
  assign LEDG  = (state != IDLE);
  assign LEDR  = ~LEDG;

endmodule

// File: tb/tb_irrigacao_zonas.sv
// Bench for irrigacao_zonas: directed key/zone scenarios, a schedule-based reference model checked every cycle,
// and hand-computed literal checkpoints.
module tb_irrigacao_zonas;
  localparam int Z      = 4;
  localparam int ZW     = $clog2(Z) + 1;
  localparam int TPS    = 10;
  localparam int DEB    = 4;
  localparam int DAWN_S = 3;
  localparam int DUSK_S = 6;
  localparam int D_DAWN = DAWN_S * TPS;
  localparam int D_DUSK = DUSK_S * TPS;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [2:0]    kb;            // {controle, anoitecer, amanhecer}, active-low
  logic [Z-1:0]  zone_en;
  logic          chuva;
  logic [Z-1:0]  valve;
  logic [ZW-1:0] zona;
  logic          LEDG, LEDR;

  irrigacao_zonas #(
    .ZONES(Z), .TICKS_PER_SEC(TPS), .DAWN_SECS(DAWN_S), .DUSK_SECS(DUSK_S), .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .amanhecer(kb[0]), .anoitecer(kb[1]), .controle(kb[2]),
    .zone_en(zone_en),
`ifdef CHUVA_EN
    .chuva(chuva),
`endif
    .valve(valve), .zona(zona), .LEDG(LEDG), .LEDR(LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Reference model: keys become presses after DEB low samples plus the 2-stage synchroniser;
  // a start lays out the whole run as per-zone time windows, shifted by rain and cut short by abort.
  int   run_lo[3], run_hi[3], pend[3];
  bit   dn[3];
  bit   act, model_ok;
  int   fin;
  int   zs[Z], ze[Z];
  bit   ch1, ch2;
  logic [Z-1:0] exp_valve;
  int   exp_zona;
  logic exp_ledg;

  initial model_ok = 1'b0;

  always @(posedge CLOCK_50) begin : model
    int n, t, dur;
    bit p[3];
    bit rain_prev, rain_now;
    n = cyc + 1;
    if (reset) begin
      model_ok = 1'b1;
      act = 1'b0;
      ch1 = 1'b0;
      ch2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        run_lo[k] = 0; run_hi[k] = 0; dn[k] = 1'b0; pend[k] = -10;
      end
      exp_valve = '0; exp_zona = 0; exp_ledg = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) p[k] = (pend[k] == n - 1);
      for (int k = 0; k < 3; k++) begin
        if (!kb[k]) begin
          run_lo[k]++; run_hi[k] = 0;
          if (!dn[k] && run_lo[k] == DEB) begin dn[k] = 1'b1; pend[k] = n + 2; end
        end else begin
          run_hi[k]++; run_lo[k] = 0;
          if (dn[k] && run_hi[k] == DEB) dn[k] = 1'b0;
        end
      end
      rain_prev = ch2;
      rain_now  = ch1;
      if (act && n - 1 > fin) act = 1'b0;
      if (act) begin
        if (p[2]) act = 1'b0;
      end else if (p[2] || (!rain_prev && (p[1] || p[0]))) begin
        act = 1'b1;
        dur = (p[2] || p[1]) ? D_DUSK : D_DAWN;
        t = n;
        for (int z = 0; z < Z; z++) begin
          t++;
          if (zone_en[z]) begin zs[z] = t; ze[z] = t + dur; t = t + dur; end
          else begin zs[z] = -1; ze[z] = -1; end
        end
        fin = t;
      end
      exp_valve = '0; exp_zona = 0; exp_ledg = 1'b0;
      if (act && n <= fin) begin
        exp_ledg = 1'b1;
        for (int z = 0; z < Z; z++) begin
          if (zs[z] >= 0 && n >= zs[z] && n < ze[z]) begin
            exp_zona = z + 1;
            if (rain_now) begin
              ze[z]++;
              for (int y = z + 1; y < Z; y++)
                if (zs[y] >= 0) begin zs[y]++; ze[y]++; end
              fin++;
            end else begin
              exp_valve[z] = 1'b1;
            end
          end
        end
      end
      ch2 = ch1;
      ch1 = chuva;
    end
  end

  int tests = 0;
  int fails = 0;
  int rel[3];
  int ch_rel;

  task automatic chk(input string nm, input int act_v, input int exp_v);
    tests++;
    if (act_v != exp_v) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    for (int k = 0; k < 3; k++)
      if (!kb[k] && cyc >= rel[k]) kb[k] = 1'b1;
    if (chuva && cyc >= ch_rel) chuva = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
    @(negedge CLOCK_50);
  endtask

  task automatic press(input logic [2:0] m, input int len, output int c);
    tick();
    for (int k = 0; k < 3; k++)
      if (m[k]) begin kb[k] = 1'b0; rel[k] = cyc + len; end
    c = cyc;
  endtask

  initial begin : stim
    int c0, c1, c2;
    reset = 1'b1; kb = 3'b111; zone_en = '0; chuva = 1'b0; ch_rel = 0;
    for (int k = 0; k < 3; k++) rel[k] = 0;

    fork
      forever begin
        @(negedge CLOCK_50);
        if (model_ok) begin
          tests++;
          if (valve !== exp_valve || zona !== ZW'(exp_zona) || LEDG !== exp_ledg || LEDR !== !exp_ledg) begin
            fails++;
            $display("FAIL model cycle %0d: valve=%b zona=%0d LEDG=%b LEDR=%b, expected valve=%b zona=%0d LEDG=%b LEDR=%b",
                     cyc, valve, zona, LEDG, LEDR, exp_valve, exp_zona, exp_ledg, !exp_ledg);
          end
        end
      end
    join_none

    repeat (3) tick();
    reset = 1'b0;
    wait_cyc(5);
    chk("reset valve", int'(valve), 0);
    chk("reset zona", int'(zona), 0);
    chk("reset LEDG", int'(LEDG), 0);
    chk("reset LEDR", int'(LEDR), 1);

    // Dawn run over all four zones.
    zone_en = 4'b1111;
    press(3'b001, 10, c0);
    wait_cyc(c0 + 7);   chk("dawn select LEDG", int'(LEDG), 1); chk("dawn select valve", int'(valve), 0);
    wait_cyc(c0 + 8);   chk("dawn z1 open", int'(valve), 1); chk("dawn z1 zona", int'(zona), 1);
    wait_cyc(c0 + 37);  chk("dawn z1 last", int'(valve), 1);
    wait_cyc(c0 + 38);  chk("dawn gap", int'(valve), 0);
    wait_cyc(c0 + 39);  chk("dawn z2 open", int'(valve), 2); chk("dawn z2 zona", int'(zona), 2);
    wait_cyc(c0 + 101); chk("dawn z4 open", int'(valve), 8); chk("dawn z4 zona", int'(zona), 4);
    wait_cyc(c0 + 131); chk("dawn final select", int'(LEDG), 1);
    wait_cyc(c0 + 132); chk("dawn done LEDG", int'(LEDG), 0); chk("dawn done LEDR", int'(LEDR), 1);
    wait_cyc(c0 + 145);

    // Dusk run with zones 2 and 4; a dawn press mid-run is ignored.
    zone_en = 4'b1010;
    press(3'b010, 10, c0);
    wait_cyc(c0 + 9);   chk("dusk z2 open", int'(valve), 2); chk("dusk z2 zona", int'(zona), 2);
    wait_cyc(c0 + 20);
    press(3'b001, 8, c1);
    wait_cyc(c0 + 68);  chk("dusk z2 last", int'(valve), 2);
    wait_cyc(c0 + 69);  chk("dusk gap a", int'(valve), 0); chk("dusk gap LEDG", int'(LEDG), 1);
    wait_cyc(c0 + 70);  chk("dusk gap b", int'(valve), 0);
    wait_cyc(c0 + 71);  chk("dusk z4 open", int'(valve), 8); chk("dusk z4 zona", int'(zona), 4);
    wait_cyc(c0 + 130); chk("dusk z4 last", int'(valve), 8);
    wait_cyc(c0 + 132); chk("dusk done", int'(LEDG), 0);
    wait_cyc(c0 + 145);

    // Abort with controle during zone 2.
    zone_en = 4'b1111;
    press(3'b001, 10, c0);
    wait_cyc(c0 + 39);  chk("abort pre z2", int'(valve), 2);
    press(3'b100, 6, c1);
    wait_cyc(c1 + 6);   chk("abort pulse valve", int'(valve), 2); chk("abort pulse LEDG", int'(LEDG), 1);
    wait_cyc(c1 + 7);   chk("abort valve", int'(valve), 0); chk("abort LEDG", int'(LEDG), 0); chk("abort LEDR", int'(LEDR), 1);
    wait_cyc(c1 + 20);

    // Three-cycle glitch is filtered out.
    press(3'b001, 3, c0);
    wait_cyc(c0 + 12);  chk("glitch LEDG", int'(LEDG), 0); chk("glitch valve", int'(valve), 0);
    wait_cyc(c0 + 20);

    // Dawn and dusk together: dusk duration wins.
    zone_en = 4'b0001;
    press(3'b011, 10, c0);
    wait_cyc(c0 + 8);   chk("both z1 open", int'(valve), 1);
    wait_cyc(c0 + 67);  chk("both z1 last", int'(valve), 1);
    wait_cyc(c0 + 68);  chk("both z1 closed", int'(valve), 0);
    wait_cyc(c0 + 71);  chk("both final select", int'(LEDG), 1);
    wait_cyc(c0 + 72);  chk("both done", int'(LEDG), 0);
    wait_cyc(c0 + 85);

    // No zones enabled: walks SELECT and returns to IDLE.
    zone_en = 4'b0000;
    press(3'b100, 6, c0);
    wait_cyc(c0 + 11);  chk("empty last select", int'(LEDG), 1); chk("empty valve", int'(valve), 0);
    wait_cyc(c0 + 12);  chk("empty done", int'(LEDG), 0);
    wait_cyc(c0 + 25);

    // Reset in the middle of watering.
    zone_en = 4'b1111;
    press(3'b001, 10, c0);
    wait_cyc(c0 + 15);  chk("pre-reset valve", int'(valve), 1);
    tick();
    reset = 1'b1;
    wait_cyc(c0 + 16);  chk("reset sampled next edge", int'(valve), 1);
    wait_cyc(c0 + 17);  chk("reset closes valve", int'(valve), 0); chk("reset LEDR", int'(LEDR), 1);
    tick();
    reset = 1'b0;
    wait_cyc(c0 + 30);

`ifdef CHUVA_EN
    // Rain for 15 cycles mid-zone pauses the valve and the timer.
    zone_en = 4'b0001;
    press(3'b001, 10, c0);
    wait_cyc(c0 + 12);
    tick();
    chuva = 1'b1; ch_rel = cyc + 15;
    wait_cyc(c0 + 14);  chk("rain pre", int'(valve), 1);
    wait_cyc(c0 + 15);  chk("rain closes", int'(valve), 0); chk("rain zona", int'(zona), 1);
    wait_cyc(c0 + 29);  chk("rain last closed", int'(valve), 0);
    wait_cyc(c0 + 30);  chk("rain resumes", int'(valve), 1);
    wait_cyc(c0 + 52);  chk("rain extended end", int'(valve), 1);
    wait_cyc(c0 + 53);  chk("rain zone done", int'(valve), 0);
    wait_cyc(c0 + 70);
    // Rain in IDLE blocks dawn but not controle.
    tick();
    chuva = 1'b1; ch_rel = cyc + 80;
    press(3'b001, 10, c1);
    wait_cyc(c1 + 10);  chk("rain blocks dawn", int'(LEDG), 0);
    press(3'b100, 6, c2);
    wait_cyc(c2 + 7);   chk("rain controle starts", int'(LEDG), 1);
    wait_cyc(c2 + 9);   chk("rain frozen valve", int'(valve), 0);
    wait_cyc(c2 + 69);  chk("rain frozen late", int'(valve), 0);
    wait_cyc(c2 + 70);  chk("rain lifted", int'(valve), 1);
    wait_cyc(c2 + 150);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
